// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: RAM word, RAM handshake state and memory arbiter state.
package cpu_types_pkg;
    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        IGNT = 2'b01,
        DGNT = 2'b10
    } arb_state_t;
endpackage

// File: rtl/arb_stats.sv
// Grant and stall statistics for mem_arbiter; all counters wrap modulo 2^CNT_W.
module arb_stats
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             i_done,
    input  logic             d_done,
    input  logic             pending,
    output logic [CNT_W-1:0] igrant_cnt,
    output logic [CNT_W-1:0] dgrant_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            igrant_cnt <= '0;
            dgrant_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (i_done) igrant_cnt <= igrant_cnt + CNT_W'(1);
            if (d_done) dgrant_cnt <= dgrant_cnt + CNT_W'(1);
            // A cycle that completes an access is progress, not a stall.
            if (pending && !(i_done || d_done)) stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single RAM port between instruction fetch and data memory, data first with a
// starvation limiter. Define ARB_STATS_EN to build the grant/stall statistics counters.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             iREN,
    input  word_t            iaddr,
    output logic             iwait,
    output word_t            iload,
    input  logic             dREN,
    input  logic             dWEN,
    input  word_t            daddr,
    input  word_t            dstore,
    output logic             dwait,
    output word_t            dload,
    output logic             ramREN,
    output logic             ramWEN,
    output word_t            ramaddr,
    output word_t            ramstore,
    input  word_t            ramload,
    input  ramstate_t        ramstate,
    output logic [CNT_W-1:0] igrant_cnt,
    output logic [CNT_W-1:0] dgrant_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIMIT);

    arb_state_t      state;
    logic [SC_W-1:0] starve_cnt;
    logic            d_req;
    logic            i_live;
    logic            d_live;
    logic            i_done;
    logic            d_done;
    logic            force_i;

    assign d_req   = dREN | dWEN;
    // A grant only drives the RAM while its owner still asserts the request.
    assign i_live  = (state == IGNT) && iREN;
    assign d_live  = (state == DGNT) && d_req;
    assign i_done  = i_live && (ramstate == ACCESS);
    assign d_done  = d_live && (ramstate == ACCESS);
    assign force_i = iREN && (starve_cnt == SC_MAX);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_req && !force_i) state <= DGNT;
                    else if (iREN)         state <= IGNT;
                end
                IGNT:    if (!iREN || i_done) state <= IDLE;
                DGNT:    if (!d_req || d_done) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (i_done) begin
                starve_cnt <= '0;
            end else if (d_done) begin
                if (!iREN)                     starve_cnt <= '0;
                else if (starve_cnt != SC_MAX) starve_cnt <= starve_cnt + SC_W'(1);
            end
        end
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        if (i_live) begin
            ramREN  = 1'b1;
            ramaddr = iaddr;
        end
        if (d_live) begin
            ramaddr  = daddr;
            ramstore = dstore;
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
        end
        if (i_done) begin
            iwait = 1'b0;
            iload = ramload;
        end
        if (d_done) begin
            dwait = 1'b0;
            dload = ramload;
        end
    end

`ifdef ARB_STATS_EN
    arb_stats #(
        .CNT_W(CNT_W)
    ) u_stats (
        .CLK       (CLK),
        .nRST      (nRST),
        .i_done    (i_done),
        .d_done    (d_done),
        .pending   (iREN | d_req),
        .igrant_cnt(igrant_cnt),
        .dgrant_cnt(dgrant_cnt),
        .stall_cnt (stall_cnt)
    );
`else
    assign igrant_cnt = '0;
    assign dgrant_cnt = '0;
    assign stall_cnt  = '0;
`endif

endmodule
